// File: rtl/commit_retire_if.sv
// commit_retire_if: bundles the commit-lane inputs, flush control and the
// registered retire outputs of the in-order retirement stage.
// master = producer/observer side, slave = the retirement stage itself.
interface commit_retire_if #(
   parameter int COMMIT_WIDTH = 4,
   parameter int RETIRE_WIDTH = 2,
   parameter int ROB_DEPTH    = 16,
   parameter int XLEN         = 64
);
   localparam int SEQ_W = $clog2(ROB_DEPTH);
   localparam int RN_W  = $clog2(RETIRE_WIDTH + 1);

   logic [COMMIT_WIDTH-1:0]                 in_valid;
   logic [COMMIT_WIDTH-1:0][SEQ_W-1:0]      in_seq;
   logic [COMMIT_WIDTH-1:0][4:0]            in_rd;
   logic [COMMIT_WIDTH-1:0][XLEN-1:0]       in_data;
   logic                                    flush;
   logic [SEQ_W-1:0]                        flush_seq;
   logic [RETIRE_WIDTH-1:0]                 rf_wen;
   logic [RETIRE_WIDTH-1:0][4:0]            rf_waddr;
   logic [RETIRE_WIDTH-1:0][XLEN-1:0]       rf_wdata;
   logic [RN_W-1:0]                         retire_num;
   logic [SEQ_W-1:0]                        head_seq;
   logic [63:0]                             instret;

   modport master (
      output in_valid, in_seq, in_rd, in_data, flush, flush_seq,
      input  rf_wen, rf_waddr, rf_wdata, retire_num, head_seq, instret
   );

   modport slave (
      input  in_valid, in_seq, in_rd, in_data, flush, flush_seq,
      output rf_wen, rf_waddr, rf_wdata, retire_num, head_seq, instret
   );
endinterface

// File: rtl/commit_retire.sv
// commit_retire: in-order retirement stage. Completed instructions arrive
// tagged with a sequence number, are parked in a sequence-indexed window and
// the contiguous oldest run (up to RETIRE_WIDTH) is retired each cycle onto
// registered register-file write ports. No backpressure: every lane is taken.
// Optional feature macro: RETIRE_INSTRET_EN builds the 64-bit retired
// instruction counter; without it instret is tied to zero.
module commit_retire #(
   parameter int COMMIT_WIDTH = 4,
   parameter int RETIRE_WIDTH = 2,
   parameter int ROB_DEPTH    = 16,
   parameter int XLEN         = 64
) (
   input  logic              clk,
   input  logic              reset,
   commit_retire_if.slave    bus
);
   localparam int SEQ_W = $clog2(ROB_DEPTH);
   localparam int RN_W  = $clog2(RETIRE_WIDTH + 1);

   logic [ROB_DEPTH-1:0]              r_valid;
   logic [4:0]                        r_rd   [ROB_DEPTH];
   logic [XLEN-1:0]                   r_data [ROB_DEPTH];
   logic [SEQ_W-1:0]                  r_head;
   logic [RETIRE_WIDTH-1:0]           r_wen;
   logic [RETIRE_WIDTH-1:0][4:0]      r_waddr;
   logic [RETIRE_WIDTH-1:0][XLEN-1:0] r_wdata;
   logic [RN_W-1:0]                   r_retire_num;

   logic [SEQ_W-1:0]                  w_idx [RETIRE_WIDTH];
   logic [RN_W-1:0]                   w_k;
   logic [ROB_DEPTH-1:0]              w_clr;
   logic [ROB_DEPTH-1:0]              w_valid_nxt;
   logic                              w_run;

   // Retire select: length of the valid run starting at head, capped.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      w_k   = '0;
      w_clr = '0;
      w_run = 1'b1;
      for (int j = 0; j < RETIRE_WIDTH; j++) begin
         w_idx[j] = r_head + SEQ_W'(j);
         if (w_run && r_valid[w_idx[j]]) begin
            w_k             = w_k + RN_W'(1);
            w_clr[w_idx[j]] = 1'b1;
         end else begin
            w_run = 1'b0;
         end
      end
   end

   // Next valid map: retired slots drop out, incoming writes (which win) set.
   always_comb begin
      w_valid_nxt = r_valid & ~w_clr;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (bus.in_valid[i]) w_valid_nxt[bus.in_seq[i]] = 1'b1;
      end
   end

   // Valid bits: cleared by reset or flush, otherwise follow the next map.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (reset || bus.flush) r_valid <= '0;
      else                    r_valid <= w_valid_nxt;
   end

   // Slot payload: the higher lane index is assigned last and therefore wins.
   always_ff @(posedge clk) begin
      // NOTE: payload storage has no reset; a slot is only read while its
      // valid bit is set, and the valid bits are reset.
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (bus.in_valid[i] && !bus.flush) begin
            r_rd[bus.in_seq[i]]   <= bus.in_rd[i];
            r_data[bus.in_seq[i]] <= bus.in_data[i];
         end
      end
   end

   // Retire commit: advance head and register the write ports.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_head       <= '0;
         r_wen        <= '0;
         r_waddr      <= '0;
         r_wdata      <= '0;
         r_retire_num <= '0;
      end else if (bus.flush) begin
         r_head       <= bus.flush_seq;
         r_wen        <= '0;
         r_retire_num <= '0;
      end else begin
         r_head       <= r_head + SEQ_W'(w_k);
         r_retire_num <= w_k;
         for (int j = 0; j < RETIRE_WIDTH; j++) begin
            r_wen[j]   <= (RN_W'(j) < w_k) && (r_rd[w_idx[j]] != 5'd0);
            r_waddr[j] <= r_rd[w_idx[j]];
            r_wdata[j] <= r_data[w_idx[j]];
         end
      end
   end

`ifdef RETIRE_INSTRET_EN
   logic [63:0] r_instret;

   // Retired-instruction counter, advancing with the registered retire count.
   always_ff @(posedge clk) begin
      if (reset)           r_instret <= '0;
      else if (!bus.flush) r_instret <= r_instret + 64'(w_k);
   end

   assign bus.instret = r_instret;
`else
   assign bus.instret = '0;
`endif

   // Producer-error checks: duplicate sequence in one cycle, or a write to a
   // slot that is still live (including one retiring at this edge).
   always_ff @(posedge clk) begin
      if (!reset && !bus.flush) begin
         for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (bus.in_valid[i]) begin
               assert (!r_valid[bus.in_seq[i]])
                  else $error("commit_retire: write to live slot %0d", bus.in_seq[i]);
               for (int m = i + 1; m < COMMIT_WIDTH; m++) begin
                  assert (!(bus.in_valid[m] && bus.in_seq[m] == bus.in_seq[i]))
                     else $error("commit_retire: lanes %0d/%0d share seq", i, m);
               end
            end
         end
      end
   end

   assign bus.rf_wen     = r_wen;
   assign bus.rf_waddr   = r_waddr;
   assign bus.rf_wdata   = r_wdata;
   assign bus.retire_num = r_retire_num;
   assign bus.head_seq   = r_head;
endmodule

// File: tb/tb_commit_retire.sv
// tb_commit_retire: directed scenarios with literal expectations, then a
// randomized run, all compared every cycle against a window model built from
// plain arrays.
module tb_commit_retire;
   localparam int CW    = 4;
   localparam int RW    = 2;
   localparam int RD    = 16;
   localparam int XL    = 64;
   localparam int SEQ_W = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   commit_retire_if #(.COMMIT_WIDTH(CW), .RETIRE_WIDTH(RW), .ROB_DEPTH(RD), .XLEN(XL)) bus ();

   commit_retire #(.COMMIT_WIDTH(CW), .RETIRE_WIDTH(RW), .ROB_DEPTH(RD), .XLEN(XL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   // Window model.
   bit          m_valid [RD];
   logic [4:0]  m_rd    [RD];
   logic [63:0] m_data  [RD];
   int          m_head;
   logic [RW-1:0] exp_wen;
   logic [4:0]    exp_waddr [RW];
   logic [63:0]   exp_wdata [RW];
   int            exp_num;
   logic [63:0]   exp_instret;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs presented now.
   task automatic model_edge();
      int k;
      int s;
      if (reset) begin
         for (int i = 0; i < RD; i++) m_valid[i] = 1'b0;
         m_head = 0; exp_wen = '0; exp_num = 0; exp_instret = '0;
         for (int j = 0; j < RW; j++) begin exp_waddr[j] = '0; exp_wdata[j] = '0; end
      end else if (bus.flush) begin
         for (int i = 0; i < RD; i++) m_valid[i] = 1'b0;
         m_head = int'(bus.flush_seq); exp_wen = '0; exp_num = 0;
      end else begin
         k = 0;
         while (k < RW && m_valid[(m_head + k) % RD]) k++;
         exp_wen = '0;
         for (int j = 0; j < k; j++) begin
            s = (m_head + j) % RD;
            exp_wen[j]   = (m_rd[s] != 5'd0);
            exp_waddr[j] = m_rd[s];
            exp_wdata[j] = m_data[s];
            m_valid[s]   = 1'b0;
         end
         exp_num = k;
         m_head  = (m_head + k) % RD;
`ifdef RETIRE_INSTRET_EN
         exp_instret = exp_instret + 64'(k);
`endif
         for (int i = 0; i < CW; i++) begin
            if (bus.in_valid[i]) begin
               s = int'(bus.in_seq[i]);
               m_valid[s] = 1'b1;
               m_rd[s]    = bus.in_rd[i];
               m_data[s]  = bus.in_data[i];
            end
         end
      end
   endtask

   // Every-cycle comparison of DUT outputs with the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("rf_wen", 64'(bus.rf_wen), 64'(exp_wen));
         check("retire_num", 64'(bus.retire_num), 64'(exp_num));
         check("head_seq", 64'(bus.head_seq), 64'(m_head));
         check("instret", bus.instret, exp_instret);
         for (int j = 0; j < RW; j++) begin
            if (exp_wen[j]) begin
               check($sformatf("rf_waddr%0d", j), 64'(bus.rf_waddr[j]), 64'(exp_waddr[j]));
               check($sformatf("rf_wdata%0d", j), bus.rf_wdata[j], exp_wdata[j]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic clear_in();
      bus.in_valid  = '0;
      bus.in_seq    = '0;
      bus.in_rd     = '0;
      bus.in_data   = '0;
      bus.flush     = 1'b0;
      bus.flush_seq = '0;
   endtask

   task automatic put(input int lane, input int seq, input int rd, input logic [63:0] data);
      bus.in_valid[lane] = 1'b1;
      bus.in_seq[lane]   = SEQ_W'(seq);
      bus.in_rd[lane]    = 5'(rd);
      bus.in_data[lane]  = data;
   endtask

   function automatic logic [63:0] ie(input int n);
`ifdef RETIRE_INSTRET_EN
      return 64'(n);
`else
      return 64'(n - n);
`endif
   endfunction

   initial begin
      bit used [RD];
      int s;
      int r;
      reset = 1'b1;
      clear_in();
      tick();
      chk_en = 1'b1;
      tick();
      reset = 1'b0;

      // Reset state.
      check("rst_wen", 64'(bus.rf_wen), 64'd0);
      check("rst_waddr", 64'(bus.rf_waddr), 64'd0);
      check("rst_wdata0", bus.rf_wdata[0], 64'd0);
      check("rst_num", 64'(bus.retire_num), 64'd0);
      check("rst_head", 64'(bus.head_seq), 64'd0);
      check("rst_instret", bus.instret, 64'd0);

      // Single instruction, two-cycle latency.
      put(0, 0, 5, 64'hAA);
      tick(); clear_in();
      check("lat_wen_early", 64'(bus.rf_wen), 64'd0);
      tick();
      check("one_wen", 64'(bus.rf_wen), 64'd1);
      check("one_waddr", 64'(bus.rf_waddr[0]), 64'd5);
      check("one_wdata", bus.rf_wdata[0], 64'hAA);
      check("one_num", 64'(bus.retire_num), 64'd1);
      check("one_head", 64'(bus.head_seq), 64'd1);

      // Mid-operation reset, then out-of-order fill of seq 0..3.
      reset = 1'b1; tick(); reset = 1'b0;
      put(0, 3, 1, 64'd100); put(1, 2, 2, 64'd101); put(2, 1, 3, 64'd102); put(3, 0, 4, 64'd103);
      tick(); clear_in(); tick();
      check("ooo_wen_a", 64'(bus.rf_wen), 64'd3);
      check("ooo_addr0_a", 64'(bus.rf_waddr[0]), 64'd4);
      check("ooo_data0_a", bus.rf_wdata[0], 64'd103);
      check("ooo_addr1_a", 64'(bus.rf_waddr[1]), 64'd3);
      check("ooo_data1_a", bus.rf_wdata[1], 64'd102);
      tick();
      check("ooo_addr0_b", 64'(bus.rf_waddr[0]), 64'd2);
      check("ooo_addr1_b", 64'(bus.rf_waddr[1]), 64'd1);
      check("ooo_data1_b", bus.rf_wdata[1], 64'd100);
      check("ooo_head", 64'(bus.head_seq), 64'd4);
      check("ooo_instret", bus.instret, ie(4));

      // Hole at head: 5 and 6 wait until 4 arrives.
      put(0, 5, 7, 64'h55); put(1, 6, 8, 64'h66);
      tick(); clear_in();
      for (int c = 0; c < 5; c++) begin
         tick();
         check("hole_wen", 64'(bus.rf_wen), 64'd0);
      end
      put(0, 4, 9, 64'h44);
      tick(); clear_in();
      check("hole_fill_early", 64'(bus.rf_wen), 64'd0);
      tick();
      check("hole_wen_a", 64'(bus.rf_wen), 64'd3);
      check("hole_addr0", 64'(bus.rf_waddr[0]), 64'd9);
      check("hole_addr1", 64'(bus.rf_waddr[1]), 64'd7);
      tick();
      check("hole_wen_b", 64'(bus.rf_wen), 64'd1);
      check("hole_data_b", bus.rf_wdata[0], 64'h66);
      check("hole_num_b", 64'(bus.retire_num), 64'd1);
      check("hole_head", 64'(bus.head_seq), 64'd7);

      // Wrap: head 15, seq 15 and 0 retire together.
      bus.flush = 1'b1; bus.flush_seq = 4'd15;
      tick(); clear_in();
      check("wrap_flush_head", 64'(bus.head_seq), 64'd15);
      put(0, 0, 11, 64'hB0); put(1, 15, 10, 64'hAF);
      tick(); clear_in(); tick();
      check("wrap_wen", 64'(bus.rf_wen), 64'd3);
      check("wrap_addr0", 64'(bus.rf_waddr[0]), 64'd10);
      check("wrap_addr1", 64'(bus.rf_waddr[1]), 64'd11);
      check("wrap_num", 64'(bus.retire_num), 64'd2);
      check("wrap_head", 64'(bus.head_seq), 64'd1);
      check("wrap_instret", bus.instret, ie(9));

      // rd == 0 retires and counts but does not write.
      put(0, 1, 0, 64'h77);
      tick(); clear_in(); tick();
      check("rd0_num", 64'(bus.retire_num), 64'd1);
      check("rd0_wen", 64'(bus.rf_wen), 64'd0);
      check("rd0_head", 64'(bus.head_seq), 64'd2);
      check("rd0_instret", bus.instret, ie(10));

      // Flush with slots 0..3 parked and a same-cycle write to the new head.
      bus.flush = 1'b1; bus.flush_seq = 4'd8;
      tick(); clear_in();
      for (int i = 0; i < 4; i++) put(i, i, 20 + i, 64'(i));
      tick(); clear_in(); tick();
      check("fl_park_wen", 64'(bus.rf_wen), 64'd0);
      bus.flush = 1'b1; bus.flush_seq = 4'd9;
      put(0, 9, 12, 64'h99);
      tick(); clear_in();
      check("fl_wen", 64'(bus.rf_wen), 64'd0);
      check("fl_num", 64'(bus.retire_num), 64'd0);
      check("fl_head", 64'(bus.head_seq), 64'd9);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("fl_idle_wen", 64'(bus.rf_wen), 64'd0);
      end
      put(0, 9, 13, 64'h9A);
      tick(); clear_in(); tick();
      check("fl_after_wen", 64'(bus.rf_wen), 64'd1);
      check("fl_after_addr", 64'(bus.rf_waddr[0]), 64'd13);
      check("fl_after_data", bus.rf_wdata[0], 64'h9A);
      check("fl_after_num", 64'(bus.retire_num), 64'd1);
      check("fl_after_head", 64'(bus.head_seq), 64'd10);
      check("fl_after_instret", bus.instret, ie(11));

      // Randomized traffic: legal writes only, occasional flush and reset.
      for (int c = 0; c < 4000; c++) begin
         clear_in();
         r = int'($urandom % 200);
         if (r < 2) reset = 1'b1;
         else if (r < 9) begin
            bus.flush     = 1'b1;
            bus.flush_seq = SEQ_W'($urandom % RD);
         end
         for (int i = 0; i < RD; i++) used[i] = m_valid[i];
         for (int i = 0; i < CW; i++) begin
            if ($urandom % 100 < 60) begin
               s = (m_head + int'($urandom_range(0, 7))) % RD;
               if (!used[s]) begin
                  used[s] = 1'b1;
                  put(i, s, ($urandom % 6 == 0) ? 0 : int'($urandom_range(1, 31)),
                      {$urandom, $urandom});
               end
            end
         end
         tick();
         reset = 1'b0;
      end
      clear_in();
      tick();
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
